display_scan_mux: RTL and testbench

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

---
 rtl/display_scan_mux.sv | 118 +++++++++++
 tb/tb_display_scan_mux.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_mux.sv
// display_scan_mux
// Time-multiplexed scan driver for a common-anode multi-digit display.
// A prescaler splits time into digit slots; each slot starts with a short
// blank window so the previous digit's segments cannot ghost onto the next.
// Once per frame (one pass over all digits) the selected time source is
// snapshotted into 'binary', so the digits shown in a frame always belong
// to the same value.
//
// Ports
//   clk_100Mhz   : clock, all state changes on the rising edge
//   reset_in     : asynchronous active-low reset
//   mode_select  : source index, applied at the next frame boundary
//   ch_data      : NUM_CH packed source values, channel k at [k*DATA_W +: DATA_W]
//   blank_mask   : per-digit force-off
//   digit_select : active-low anode enables (at most one low)
//   digit_index  : current slot number
//   binary       : frame snapshot of the selected source
//   frame_tick   : one-cycle pulse in the first cycle of each new frame
module display_scan_mux #(
  parameter int NUM_DIGITS  = 8,
  parameter int NUM_CH      = 3,
  parameter int DATA_W      = 27,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 1000,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int IDX_W = $clog2(NUM_DIGITS),
  localparam int CNT_W = $clog2(REFRESH_DIV)
) (
  input  logic                     clk_100Mhz,
  input  logic                     reset_in,
  input  logic [SEL_W-1:0]         mode_select,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_DIGITS-1:0]    blank_mask,
  output logic [NUM_DIGITS-1:0]    digit_select,
  output logic [IDX_W-1:0]         digit_index,
  output logic [DATA_W-1:0]        binary,
  output logic                     frame_tick
);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  prime_q;
  logic [DATA_W-1:0]     binary_d;
  logic [NUM_DIGITS-1:0] digit_select_d;
  logic                  frame_tick_d;

  logic slotEnd;
  logic frameEnd;
  logic loadSnap;
  logic [DATA_W-1:0] selectedChan;

  // Slot and frame boundaries are decoded from the current count so the
  // edge that wraps the prescaler is also the edge that advances the digit.
  assign slotEnd  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign frameEnd = slotEnd && (digit_index == IDX_W'(NUM_DIGITS - 1));

  // The first edge after reset primes the snapshot so the display does not
  // sit on zero for a whole frame; afterwards only frame boundaries load.
  assign loadSnap = prime_q || frameEnd;

  assign selectedChan = DATA_W'(ch_data >> (int'(sel_q) * DATA_W));

  // Next-state logic. digit_select is computed from the next count/index so
  // the registered enable always matches the slot state of the same cycle.
  always_comb begin
    cnt_d          = cnt_q + CNT_W'(1);
    idx_d          = digit_index;
    sel_d          = sel_q;
    binary_d       = binary;
    frame_tick_d   = frameEnd;
    digit_select_d = '1;

    if (slotEnd) begin
      cnt_d = '0;
      if (digit_index == IDX_W'(NUM_DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = digit_index + IDX_W'(1);
      end
    end

    // Capture uses the old selector; an out-of-range index keeps the
    // previous source rather than showing garbage.
    if (loadSnap) begin
      binary_d = selectedChan;
      if (int'(mode_select) < NUM_CH) begin
        sel_d = mode_select;
      end
    end

    if ((cnt_d >= CNT_W'(DEAD_CYCLES)) && !blank_mask[idx_d]) begin
      digit_select_d = ~(NUM_DIGITS'(1) << idx_d);
    end
  end

  // State and output registers.
  always_ff @(posedge clk_100Mhz or negedge reset_in) begin
    if (!reset_in) begin
      cnt_q        <= '0;
      digit_index  <= '0;
      sel_q        <= '0;
      binary       <= '0;
      frame_tick   <= 1'b0;
      digit_select <= '1;
      prime_q      <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      digit_index  <= idx_d;
      sel_q        <= sel_d;
      binary       <= binary_d;
      frame_tick   <= frame_tick_d;
      digit_select <= digit_select_d;
      prime_q      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux
// Small configuration: 4 digits, 3 channels of 8 bits, 4-cycle slots with a
// 1-cycle blank, so one frame lasts 16 cycles.
module tb_display_scan_mux;

  localparam int ND = 4;
  localparam int NC = 3;
  localparam int DW = 8;
  localparam int RD = 4;
  localparam int DC = 1;

  logic          clk;
  logic          resetIn;
  logic [1:0]    modeSelect;
  logic [NC*DW-1:0] chData;
  logic [ND-1:0] blankMask;
  logic [ND-1:0] digitSelect;
  logic [1:0]    digitIndex;
  logic [DW-1:0] binaryOut;
  logic          frameTick;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  display_scan_mux #(
    .NUM_DIGITS (ND),
    .NUM_CH     (NC),
    .DATA_W     (DW),
    .REFRESH_DIV(RD),
    .DEAD_CYCLES(DC)
  ) dut (
    .clk_100Mhz  (clk),
    .reset_in    (resetIn),
    .mode_select (modeSelect),
    .ch_data     (chData),
    .blank_mask  (blankMask),
    .digit_select(digitSelect),
    .digit_index (digitIndex),
    .binary      (binaryOut),
    .frame_tick  (frameTick)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (cyc %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic [ND-1:0] blank,
                               input logic [NC*DW-1:0] data);
    modeSelect = mode;
    blankMask  = blank;
    chData     = data;
  endtask

  // Advance to a given cycle count, one falling edge per cycle.
  task automatic stepTo(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_sel"},  32'(digitSelect), 32'hF);
    checkOutput({tag, "_idx"},  32'(digitIndex), 32'd0);
    checkOutput({tag, "_bin"},  32'(binaryOut), 32'd0);
    checkOutput({tag, "_tick"}, 32'(frameTick), 32'd0);
  endtask

  // Scoreboard: a cycle model advances on each active edge and pushes the
  // outputs expected for the following cycle; the monitor pops on the
  // falling edge and compares.
  typedef struct {
    logic [ND-1:0] sel;
    logic [1:0]    idx;
    logic [DW-1:0] bin;
    logic          tick;
  } expT;

  expT sbq[$];
  expT modelE;
  expT monE;
  int  mCnt, mIdx, mSel;
  logic [DW-1:0] mBin;
  bit  mPrime;
  bit  mFrameEdge;

  always @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      mCnt = 0; mIdx = 0; mSel = 0; mBin = '0; mPrime = 1'b1;
      sbq.delete();
    end else begin
      mFrameEdge = (mCnt == RD - 1) && (mIdx == ND - 1);
      if (mPrime || mFrameEdge) begin
        mBin = chData[mSel*DW +: DW];
        if (int'(modeSelect) < NC) mSel = int'(modeSelect);
      end
      mPrime = 1'b0;
      if (mCnt == RD - 1) begin
        mCnt = 0;
        mIdx = (mIdx + 1) % ND;
      end else begin
        mCnt++;
      end
      modelE.sel  = (mCnt < DC || blankMask[mIdx]) ? 4'hF : ~(4'b0001 << mIdx);
      modelE.idx  = 2'(mIdx);
      modelE.bin  = mBin;
      modelE.tick = mFrameEdge;
      sbq.push_back(modelE);
    end
  end

  always @(negedge clk) begin
    if (!resetIn) begin
      checkResetValues("sbReset");
    end else if (sbq.size() > 0) begin
      monE = sbq.pop_front();
      checkOutput("sbDigitSelect", 32'(digitSelect), 32'(monE.sel));
      checkOutput("sbDigitIndex",  32'(digitIndex),  32'(monE.idx));
      checkOutput("sbBinary",      32'(binaryOut),   32'(monE.bin));
      checkOutput("sbFrameTick",   32'(frameTick),   32'(monE.tick));
      checkOutput("onehot", 32'($countones(~digitSelect) <= 1), 32'd1);
    end
  end

  // Scan-order table for the first two frames after reset release.
  typedef struct {
    logic [ND-1:0] blank;
    logic [ND-1:0] expSel;
    logic [1:0]    expIdx;
    logic [DW-1:0] expBin;
    logic          expTick;
  } vecT;

  vecT tbl[32];

  localparam logic [NC*DW-1:0] DATA0 = {8'hA7, 8'h09, 8'h05};

  initial begin
    int slot;
    int c;
    logic [ND-1:0] bl;

    // Slot s/4, count s%4; the mask 0100 from sample 16 on blanks slot 2
    // of the second frame only.
    for (int s = 0; s < 32; s++) begin
      slot = (s / 4) % 4;
      c    = s % 4;
      bl   = (s >= 16) ? 4'b0100 : 4'b0000;
      tbl[s].blank   = bl;
      tbl[s].expSel  = (c == 0 || (s >= 17 && slot == 2)) ? 4'hF : ~(4'b0001 << slot);
      tbl[s].expIdx  = 2'(slot);
      tbl[s].expBin  = (s == 0) ? 8'h00 : 8'h05;
      tbl[s].expTick = (s == 16);
    end

    resetIn = 1'b0;
    applyStimulus(2'd0, 4'b0000, DATA0);
    repeat (3) @(negedge clk);
    #1;
    checkResetValues("reset");
    resetIn = 1'b1;
    cyc = 0;

    // Scan order, blanking and frame tick over two frames.
    for (int s = 0; s < 32; s++) begin
      stepTo(s);
      checkOutput("scanSel",  32'(digitSelect), 32'(tbl[s].expSel));
      checkOutput("scanIdx",  32'(digitIndex),  32'(tbl[s].expIdx));
      checkOutput("scanBin",  32'(binaryOut),   32'(tbl[s].expBin));
      checkOutput("scanTick", 32'(frameTick),   32'(tbl[s].expTick));
      applyStimulus(2'd0, tbl[s].blank, DATA0);
    end

    // Mode change mid-frame: the boundary at 48 still captures channel 0,
    // the boundary at 64 captures channel 1.
    stepTo(34);
    applyStimulus(2'd1, 4'b0000, DATA0);
    stepTo(47);
    checkOutput("modeBinPre", 32'(binaryOut), 32'h05);
    stepTo(48);
    checkOutput("modeTick1", 32'(frameTick), 32'd1);
    checkOutput("modeBin1",  32'(binaryOut), 32'h05);
    stepTo(63);
    checkOutput("modeBinMid", 32'(binaryOut), 32'h05);
    stepTo(64);
    checkOutput("modeTick2", 32'(frameTick), 32'd1);
    checkOutput("modeBin2",  32'(binaryOut), 32'h09);

    // Out-of-range selector holds channel 1, which keeps being tracked.
    stepTo(70);
    applyStimulus(2'd3, 4'b0000, DATA0);
    stepTo(80);
    checkOutput("oorBin1", 32'(binaryOut), 32'h09);
    stepTo(85);
    applyStimulus(2'd3, 4'b0000, {8'hA7, 8'h3C, 8'h05});
    stepTo(96);
    checkOutput("oorBin2", 32'(binaryOut), 32'h3C);
    stepTo(100);
    applyStimulus(2'd2, 4'b0000, {8'hA7, 8'h3C, 8'h05});
    stepTo(112);
    checkOutput("oorBin3", 32'(binaryOut), 32'h3C);
    stepTo(128);
    checkOutput("oorBin4", 32'(binaryOut), 32'hA7);

    // Asynchronous reset at digit 2, count 3, between clock edges.
    stepTo(139);
    checkOutput("preRstIdx", 32'(digitIndex), 32'd2);
    #2;
    resetIn = 1'b0;
    #1;
    checkResetValues("asyncReset");
    applyStimulus(2'd2, 4'b0000, {8'hA7, 8'h3C, 8'h11});
    repeat (2) @(negedge clk);
    #1;
    resetIn = 1'b1;
    cyc = 0;
    checkOutput("postRstSel", 32'(digitSelect), 32'hF);
    stepTo(1);
    checkOutput("primeBin",  32'(binaryOut),   32'h11);
    checkOutput("primeTick", 32'(frameTick),   32'd0);
    checkOutput("primeSel",  32'(digitSelect), 32'hE);
    checkOutput("primeIdx",  32'(digitIndex),  32'd0);
    stepTo(16);
    checkOutput("postRstTick", 32'(frameTick), 32'd1);
    checkOutput("postRstBin",  32'(binaryOut), 32'hA7);

    // Random stimulus; the monitor checks the one-hot property each cycle.
    for (int r = 0; r < 300; r++) begin
      stepTo(cyc + 1);
      applyStimulus(2'($urandom_range(0, 3)), 4'($urandom), 24'($urandom));
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    mismatched++;
    $display("[TB] FAIL watchdog: run did not complete, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
